// File: rtl/cache_pkg.sv
// Shared constants for the D-cache block-transfer interface: block size, beat-counter
// width and the 3-bit state encoding of the DRAM responder FSM.
package cache_pkg;

    localparam int BLOCK_SIZE = 8;
    localparam int BEAT_W     = $clog2(BLOCK_SIZE) + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_BEAT = 3'd2;
    localparam logic [2:0] ST_WR_GAP  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RD_BEAT = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // True for the states in which a burst is still collecting or issuing beats.
    function automatic logic st_is_active(input logic [2:0] st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/dram_sim_ram.sv
// Single-port synchronous word RAM, 2**ADDR_W words.
// Latency: 1 cycle read (old data on read-during-write). Backpressure: none; every cycle performs a read.
// Backpressure: none, the caller owns all timing through address and write enable.
module dram_sim_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdat,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdat;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdat <= '0;
        end else begin
            r_rdat <= r_mem[i_addr];
        end
    end

    assign o_rdat = r_rdat;

endmodule

// File: rtl/dram_burst_responder.sv
// DRAM-side responder serving 8-beat write-back and refill bursts from an internal word array.
// Latency: first wr beat WR_LAT and first rd beat RD_LAT cycles after acceptance; wr beats every other cycle.
// Backpressure: none; requester holds a level req, dropping it early aborts the burst next cycle.
module dram_burst_responder #(
    parameter int ADDR_W     = 14,
    parameter int BLOCK_SIZE = cache_pkg::BLOCK_SIZE,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dram_wr_req,
    input  logic [31:0] dram_wr_addr,
    input  logic [31:0] dram_wr_data,
    output logic        dram_wr_val,
    input  logic        dram_rd_req,
    input  logic [31:0] dram_rd_addr,
    output logic [31:0] dram_rd_data,
    output logic        dram_rd_val
);
    import cache_pkg::*;

    localparam int BW = $clog2(BLOCK_SIZE) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);
    localparam logic [3:0] WR_LAT_LD = 4'(WR_LAT - 1);
    // RD_WAIT lasts RD_LAT-1 cycles because the RAM read register supplies the final cycle.
    localparam logic [3:0] RD_LAT_LD = 4'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [2:0] RD_FIRST  = (RD_LAT > 1) ? ST_RD_WAIT : ST_RD_BEAT;

    logic [2:0]        r_state;
    logic [2:0]        w_nxt_state;
    logic [BW-1:0]     r_beat;
    logic [3:0]        r_lat;
    logic [ADDR_W-1:0] r_base;
    logic              r_is_wr;
    logic              r_wr_val;
    logic              r_rd_val;

    logic              w_last;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_rdat;
    logic              w_unused;

    assign w_last     = (r_beat == LAST_BEAT);
    assign w_ram_we   = (r_state == ST_WR_BEAT);
    assign w_ram_addr = r_base + ADDR_W'(r_beat);
    assign w_unused   = ^{dram_wr_addr[31:ADDR_W], dram_rd_addr[31:ADDR_W]};

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dram_wr_req) begin
                    w_nxt_state = ST_WR_WAIT;
                end else if (dram_rd_req) begin
                    w_nxt_state = RD_FIRST;
                end
            end
            ST_WR_WAIT: begin
                if (!dram_wr_req) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_lat == 4'd0) begin
                    w_nxt_state = ST_WR_BEAT;
                end
            end
            ST_WR_BEAT: begin
                if (w_last) begin
                    w_nxt_state = ST_DONE;
                end else if (!dram_wr_req) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_WR_GAP;
                end
            end
            ST_WR_GAP: begin
                w_nxt_state = dram_wr_req ? ST_WR_BEAT : ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (!dram_rd_req) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_lat == 4'd0) begin
                    w_nxt_state = ST_RD_BEAT;
                end
            end
            ST_RD_BEAT: begin
                if (!dram_rd_req) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_last) begin
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only the finished burst's req matters, so a wr->rd handoff re-enters via IDLE.
                if (r_is_wr ? !dram_wr_req : !dram_rd_req) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_lat    <= '0;
            r_base   <= '0;
            r_is_wr  <= 1'b0;
            r_wr_val <= 1'b0;
            r_rd_val <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_wr_val <= (w_nxt_state == ST_WR_BEAT);
            // The rd beat issued this cycle surfaces next cycle unless the burst is aborted.
            r_rd_val <= (r_state == ST_RD_BEAT) && dram_rd_req;
            case (r_state)
                ST_IDLE: begin
                    r_beat <= '0;
                    if (dram_wr_req) begin
                        r_base  <= dram_wr_addr[ADDR_W-1:0];
                        r_is_wr <= 1'b1;
                        r_lat   <= WR_LAT_LD;
                    end else if (dram_rd_req) begin
                        r_base  <= dram_rd_addr[ADDR_W-1:0];
                        r_is_wr <= 1'b0;
                        r_lat   <= RD_LAT_LD;
                    end
                end
                ST_WR_WAIT, ST_RD_WAIT: begin
                    if (r_lat != 4'd0) begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                ST_WR_BEAT, ST_RD_BEAT: begin
                    if (st_is_active(w_nxt_state) || (w_nxt_state == ST_DONE)) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dram_sim_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdat (dram_wr_data),
        .o_rdat (w_ram_rdat)
    );

    assign dram_wr_val  = r_wr_val;
    assign dram_rd_val  = r_rd_val;
    assign dram_rd_data = w_ram_rdat;

endmodule

// File: tb/tb_dram_burst_responder.sv
// Bench for dram_burst_responder: a cycle-indexed expectation table filled from burst timing
// rules and a word-array memory model, compared against the DUT on every cycle.
module tb_dram_burst_responder;

    localparam int ADDR_W = 14;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 4;
    localparam int NW     = 1 << ADDR_W;
    localparam int NCYC   = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dram_wr_req;
    logic [31:0] dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic        dram_wr_val;
    logic        dram_rd_req;
    logic [31:0] dram_rd_addr;
    logic [31:0] dram_rd_data;
    logic        dram_rd_val;

    dram_burst_responder #(
        .ADDR_W     (ADDR_W),
        .BLOCK_SIZE (8),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dram_wr_req  (dram_wr_req),
        .dram_wr_addr (dram_wr_addr),
        .dram_wr_data (dram_wr_data),
        .dram_wr_val  (dram_wr_val),
        .dram_rd_req  (dram_rd_req),
        .dram_rd_addr (dram_rd_addr),
        .dram_rd_data (dram_rd_data),
        .dram_rd_val  (dram_rd_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          exp_wr  [NCYC];
    bit          exp_rd  [NCYC];
    bit          exp_dk  [NCYC];
    logic [31:0] exp_dat [NCYC];
    bit          obs_wr  [NCYC];
    bit          obs_rd  [NCYC];
    logic [31:0] obs_dat [NCYC];
    logic [31:0] mem_model [NW];
    bit          mem_known [NW];
    logic [31:0] wbuf [8];
    int          wbases [$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic int widx(input logic [31:0] a, input int j);
        return int'((a + 32'(j)) & 32'(NW - 1));
    endfunction

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cyc < NCYC) begin
            obs_wr[cyc]  = dram_wr_val;
            obs_rd[cyc]  = dram_rd_val;
            obs_dat[cyc] = dram_rd_data;
            check("wr_val", 32'(dram_wr_val), 32'(exp_wr[cyc]));
            check("rd_val", 32'(dram_rd_val), 32'(exp_rd[cyc]));
            if (exp_rd[cyc] && exp_dk[cyc]) check("rd_data", dram_rd_data, exp_dat[cyc]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write burst of nb beats (8 = complete); returns at the negedge where req is dropped.
    task automatic wr_burst(input logic [31:0] addr, input int nb, output int acc);
        int b0, last_c, k;
        dram_wr_req  = 1'b1;
        dram_wr_addr = addr;
        dram_wr_data = wbuf[0];
        acc = cyc + 1;
        b0  = acc + WR_LAT;
        for (int j = 0; j < nb; j++) begin
            if (b0 + 2 * j < NCYC) exp_wr[b0 + 2 * j] = 1'b1;
            mem_model[widx(addr, j)] = wbuf[j];
            mem_known[widx(addr, j)] = 1'b1;
        end
        last_c = (nb == 8) ? b0 + 16 : b0 + 2 * (nb - 1) + 1;
        forever begin
            @(negedge clk);
            if (cyc >= last_c) break;
            // Cache data follows its beat counter one cycle late: word k holds from beat k to its gap.
            k = (cyc - b0) / 2;
            if (k < 0) k = 0;
            if (k > 7) k = 7;
            dram_wr_data = wbuf[k];
        end
        dram_wr_req = 1'b0;
    endtask

    // Full read burst; dly=1 when the request is raised while the DUT still sits in DONE.
    task automatic rd_burst(input logic [31:0] addr, input int dly, output int acc);
        int f, last_c;
        dram_rd_req  = 1'b1;
        dram_rd_addr = addr;
        acc = cyc + 1 + dly;
        f   = acc + RD_LAT;
        for (int j = 0; j < 8; j++) begin
            if (f + j < NCYC) begin
                exp_rd[f + j]  = 1'b1;
                exp_dk[f + j]  = mem_known[widx(addr, j)];
                exp_dat[f + j] = mem_model[widx(addr, j)];
            end
        end
        last_c = f + 9;
        forever begin
            @(negedge clk);
            if (cyc >= last_c) break;
        end
        dram_rd_req = 1'b0;
    endtask

    initial begin
        int acc, acc2, f, h;
        logic [31:0] a;
        rst_n        = 1'b0;
        dram_wr_req  = 1'b0;
        dram_rd_req  = 1'b0;
        dram_wr_addr = '0;
        dram_rd_addr = '0;
        dram_wr_data = '0;
        idle(3);
        check("reset_wr_val", 32'(dram_wr_val), 32'd0);
        check("reset_rd_val", 32'(dram_rd_val), 32'd0);
        check("reset_rd_data", dram_rd_data, 32'd0);
        #2 rst_n = 1'b1;
        idle(3);

        // Preload 0x100 with A0..A7 and read it back.
        for (int j = 0; j < 8; j++) wbuf[j] = 32'hA0 + 32'(j);
        wr_burst(32'h100, 8, acc);
        idle(2);
        rd_burst(32'h100, 0, acc);
        idle(2);
        check("rd_pre_first", 32'(obs_rd[acc + 3]), 32'd0);
        check("rd_first_val", 32'(obs_rd[acc + 4]), 32'd1);
        check("rd_first_dat", obs_dat[acc + 4], 32'hA0);
        check("rd_last_dat", obs_dat[acc + 11], 32'hA7);
        check("rd_after_last", 32'(obs_rd[acc + 12]), 32'd0);

        // Write burst to 0x200: beats on cycles 4,6,..,18 after acceptance.
        for (int j = 0; j < 8; j++) wbuf[j] = 32'hC0DE_0000 + 32'(j * 17);
        wr_burst(32'h200, 8, acc);
        idle(2);
        check("wr_beat0", 32'(obs_wr[acc + 4]), 32'd1);
        check("wr_gap0", 32'(obs_wr[acc + 5]), 32'd0);
        check("wr_beat7", 32'(obs_wr[acc + 18]), 32'd1);
        check("wr_after7", 32'(obs_wr[acc + 19]), 32'd0);
        rd_burst(32'h200, 0, acc);
        idle(2);
        check("wr_readback5", obs_dat[acc + 9], 32'hC0DE_0055);

        // Dirty miss: write 0x300 then hand off straight to a refill of 0x500.
        for (int j = 0; j < 8; j++) wbuf[j] = 32'h5500_0000 + 32'(j);
        wr_burst(32'h500, 8, acc);
        idle(2);
        for (int j = 0; j < 8; j++) wbuf[j] = 32'h3300_0000 + 32'(j);
        wr_burst(32'h300, 8, acc);
        h = cyc;
        rd_burst(32'h500, 1, acc2);
        idle(2);
        check("handoff_pre", 32'(obs_rd[h + 1 + RD_LAT]), 32'd0);
        check("handoff_beat0", 32'(obs_rd[h + 2 + RD_LAT]), 32'd1);
        check("handoff_dat0", obs_dat[h + 2 + RD_LAT], 32'h5500_0000);
        rd_burst(32'h300, 0, acc);
        idle(2);

        // Wrap at the top of the array; upper address bits are ignored.
        for (int j = 0; j < 8; j++) wbuf[j] = 32'hE000_0000 + 32'(j);
        wr_burst(32'(NW - 8), 8, acc);
        idle(2);
        for (int j = 0; j < 8; j++) wbuf[j] = 32'h0000_F000 + 32'(j);
        wr_burst(32'h0, 8, acc);
        idle(2);
        rd_burst(32'h7A50_0000 | 32'(NW - 4), 0, acc);
        idle(2);
        check("wrap_beat3", obs_dat[acc + 7], 32'hE000_0007);
        check("wrap_beat4", obs_dat[acc + 8], 32'h0000_F000);

        // Abort a write after beat 2: only three words change.
        for (int j = 0; j < 8; j++) wbuf[j] = 32'h6600_0000 + 32'(j);
        wr_burst(32'h600, 8, acc);
        idle(2);
        for (int j = 0; j < 8; j++) wbuf[j] = 32'hBAD0_0000 + 32'(j);
        wr_burst(32'h600, 3, acc);
        idle(2);
        check("abort_no_beat3", 32'(obs_wr[acc + 10]), 32'd0);
        rd_burst(32'h600, 0, acc);
        idle(2);
        check("abort_kept2", obs_dat[acc + 6], 32'hBAD0_0002);
        check("abort_old3", obs_dat[acc + 7], 32'h6600_0003);

        // Reset during beat 3 of a refill.
        dram_rd_req  = 1'b1;
        dram_rd_addr = 32'h100;
        acc = cyc + 1;
        f   = acc + RD_LAT;
        for (int j = 0; j < 4; j++) begin
            exp_rd[f + j]  = 1'b1;
            exp_dk[f + j]  = 1'b1;
            exp_dat[f + j] = 32'hA0 + 32'(j);
        end
        while (cyc < f + 3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_rd_val", 32'(dram_rd_val), 32'd0);
        check("rst_mid_rd_data", dram_rd_data, 32'd0);
        dram_rd_req = 1'b0;
        idle(2);
        #2 rst_n = 1'b1;
        idle(4);
        rd_burst(32'h100, 0, acc);
        idle(2);
        check("post_rst_dat0", obs_dat[acc + 4], 32'hA0);

        // Randomised traffic against the memory model.
        for (int i = 0; i < 30; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 1 && wbases.size() > 0) begin
                a = 32'(wbases[$urandom_range(0, wbases.size() - 1)]) | ($urandom << ADDR_W);
                rd_burst(a, 0, acc);
            end else begin
                a = $urandom & 32'hFFFF_FFF8;
                for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
                wr_burst(a, 8, acc);
                wbases.push_back(int'(a & 32'(NW - 1)));
                if (op == 2) begin
                    a = 32'(wbases[$urandom_range(0, wbases.size() - 1)]);
                    rd_burst(a, 1, acc);
                end
            end
            idle($urandom_range(1, 4));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
